// File: rtl/button_conditioner.sv
// Per-channel front-panel input conditioner: 2-FF synchroniser, debounce, press/release
// pulses and long-press detection with auto-repeat, all in the clk domain.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] long_press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [HC_W-1:0] HOLD_END = HC_W'(HOLD_CYCLES);
  localparam logic [HC_W-1:0] REP_END  = HC_W'(REPEAT_CYCLES);
  localparam logic [HC_W-1:0] HC_ONE   = HC_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic            s1, s2;
    logic            accept;
    logic            lvl;
    logic            rise, fall;
    logic            press_r, release_r, repeat_r, long_r;
    logic [DB_W-1:0] db_cnt;
    logic [HC_W-1:0] hold_cnt;
    state_t          state;

    // accept marks that the new value has been stable long enough; level flips on the next edge
    assign rise = accept & ~lvl;
    assign fall = accept & lvl;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        db_cnt    <= '0;
        accept    <= 1'b0;
        lvl       <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        s1        <= btn_raw[i];
        s2        <= s1;
        press_r   <= rise;
        release_r <= fall;
        accept    <= 1'b0;
        if (accept) begin
          lvl <= ~lvl;
          // s2 still at the old level already disagrees with the new one: count it
          db_cnt <= (s2 == lvl) ? DB_ONE : '0;
        end else if (s2 == lvl) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt <= '0;
          accept <= 1'b1;
        end else begin
          db_cnt <= db_cnt + DB_ONE;
        end
      end
    end

    // Hold / auto-repeat FSM; a release on the same edge as a due repeat suppresses it
    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= IDLE;
        hold_cnt <= '0;
        repeat_r <= 1'b0;
        long_r   <= 1'b0;
      end else begin
        repeat_r <= 1'b0;
        if (fall) begin
          state    <= IDLE;
          hold_cnt <= '0;
          long_r   <= 1'b0;
        end else begin
          unique case (state)
            IDLE: begin
              if (rise) begin
                state    <= HELD;
                hold_cnt <= HC_ONE;
              end
            end
            HELD: begin
              if (hold_cnt == HOLD_END) begin
                state    <= REPEAT;
                hold_cnt <= HC_ONE;
                repeat_r <= 1'b1;
                long_r   <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + HC_ONE;
              end
            end
            REPEAT: begin
              if (hold_cnt == REP_END) begin
                hold_cnt <= HC_ONE;
                repeat_r <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + HC_ONE;
              end
            end
            default: begin
              state    <= IDLE;
              hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign level[i]         = lvl;
    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = release_r;
    assign repeat_pulse[i]  = repeat_r;
    assign long_press[i]    = long_r;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected output events with
// their cycle stamps, a negedge monitor matches every observed event against the queue.
module tb_button_conditioner;

  localparam int N   = 2;
  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int REP = 5;

  localparam int K_PRESS  = 0;
  localparam int K_REL    = 1;
  localparam int K_REP    = 2;
  localparam int K_LP_ON  = 3;
  localparam int K_LP_OFF = 4;
  localparam int K_LVL_UP = 5;
  localparam int K_LVL_DN = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] level, press_pulse, release_pulse, repeat_pulse, long_press;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t      exp_q[$];
  int       cyc      = 0;
  int       n_checks = 0;
  int       n_fail   = 0;
  bit       mon_en   = 1'b0;
  logic [N-1:0] prev_lvl, prev_lp;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_PRESS:  return "press_pulse";
      K_REL:    return "release_pulse";
      K_REP:    return "repeat_pulse";
      K_LP_ON:  return "long_press_rise";
      K_LP_OFF: return "long_press_fall";
      K_LVL_UP: return "level_rise";
      default:  return "level_fall";
    endcase
  endfunction

  task automatic push(int at, int c, int kind);
    ev_t e;
    e.cyc  = at;
    e.ch   = c;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic expect_press(int at, int c);
    push(at, c, K_PRESS);
    push(at, c, K_LVL_UP);
  endtask

  task automatic expect_release(int at, int c, bit was_long);
    push(at, c, K_REL);
    push(at, c, K_LVL_DN);
    if (was_long) push(at, c, K_LP_OFF);
  endtask

  task automatic observe(int c, int kind);
    int idx = -1;
    n_checks++;
    foreach (exp_q[j])
      if (idx < 0 && exp_q[j].cyc == cyc && exp_q[j].ch == c && exp_q[j].kind == kind) idx = j;
    if (idx >= 0) exp_q.delete(idx);
    else begin
      n_fail++;
      $display("FAIL %s ch%0d: seen at cycle %0d, required: no such event at that cycle",
               kname(kind), c, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < N; c++) begin
        if (press_pulse[c] === 1'b1)   observe(c, K_PRESS);
        if (release_pulse[c] === 1'b1) observe(c, K_REL);
        if (repeat_pulse[c] === 1'b1)  observe(c, K_REP);
        if (long_press[c] !== prev_lp[c]) begin
          observe(c, (long_press[c] === 1'b1) ? K_LP_ON : K_LP_OFF);
          prev_lp[c] = long_press[c];
        end
        if (level[c] !== prev_lvl[c]) begin
          observe(c, (level[c] === 1'b1) ? K_LVL_UP : K_LVL_DN);
          prev_lvl[c] = level[c];
        end
      end
    end
  end

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(string name);
    logic [5*N-1:0] got;
    got = {level, press_pulse, release_pulse, repeat_pulse, long_press};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%b, required all zero", name, got);
    end
  endtask

  initial begin
    int k, p, p0, p1;
    reset   = 1'b1;
    btn_raw = '0;

    // 1: reset, then idle with inputs low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    n_checks++;
    if (level !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_level: level=%b, required 00", level);
    end
    prev_lvl = '0;
    prev_lp  = '0;
    reset    = 1'b0;
    mon_en   = 1'b1;
    k = cyc;
    wait_until(k + 50);
    check_all_zero("idle_50");

    // 2: clean press then release on ch0
    k = cyc;
    btn_raw[0] = 1'b1;
    expect_press(k + 7, 0);
    wait_until(k + 8);
    btn_raw[0] = 1'b0;
    expect_release(k + 15, 0, 1'b0);
    wait_until(k + 25);

    // 3: 3-cycle bounce rejected, 4-cycle pulse accepted
    k = cyc;
    btn_raw[0] = 1'b1;
    wait_until(k + 3);
    btn_raw[0] = 1'b0;
    wait_until(k + 15);
    k = cyc;
    btn_raw[0] = 1'b1;
    expect_press(k + 7, 0);
    wait_until(k + 4);
    btn_raw[0] = 1'b0;
    expect_release(k + 11, 0, 1'b0);
    wait_until(k + 20);

    // 4: long hold on ch0 with auto-repeat
    k = cyc;
    p = k + 7;
    btn_raw[0] = 1'b1;
    expect_press(p, 0);
    push(p + HLD, 0, K_LP_ON);
    for (int m = 0; m < 10; m++) push(p + HLD + REP * m, 0, K_REP);
    wait_until(p + 60);
    btn_raw[0] = 1'b0;
    expect_release(p + 67, 0, 1'b1);
    wait_until(p + 80);

    // 5: two channels, ch1 released early, ch0 release lands on a repeat edge
    k  = cyc;
    p0 = k + 7;
    p1 = k + 9;
    btn_raw[0] = 1'b1;
    expect_press(p0, 0);
    push(p0 + HLD, 0, K_LP_ON);
    for (int m = 0; m < 3; m++) push(p0 + HLD + REP * m, 0, K_REP);
    wait_until(k + 2);
    btn_raw[1] = 1'b1;
    expect_press(p1, 1);
    wait_until(p1 + 10);
    btn_raw[1] = 1'b0;
    expect_release(p1 + 17, 1, 1'b0);
    wait_until(p0 + 28);
    btn_raw[0] = 1'b0;
    expect_release(p0 + 35, 0, 1'b1);
    wait_until(p0 + 45);

    // 6: reset while ch0 is repeating, button still held
    k = cyc;
    p = k + 7;
    btn_raw[0] = 1'b1;
    expect_press(p, 0);
    push(p + HLD, 0, K_LP_ON);
    push(p + HLD, 0, K_REP);
    wait_until(p + 22);
    reset = 1'b1;
    push(p + 23, 0, K_LVL_DN);
    push(p + 23, 0, K_LP_OFF);
    wait_until(p + 23);
    check_all_zero("reset_mid_hold");
    wait_until(p + 25);
    reset = 1'b0;
    expect_press(p + 32, 0);
    wait_until(p + 36);
    btn_raw[0] = 1'b0;
    expect_release(p + 43, 0, 1'b0);
    wait_until(p + 55);

    // anything still queued never appeared
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d events pending, required 0", exp_q.size());
      foreach (exp_q[j])
        $display("FAIL missing %s ch%0d: not seen, required at cycle %0d",
                 kname(exp_q[j].kind), exp_q[j].ch, exp_q[j].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
